// File: rtl/cpu_wb_if.sv
// cpu_wb_if: writeback request channels, issue reservation, hazard query and register-file write port
interface cpu_wb_if #(parameter int XLEN = 32);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      a1;
  logic [4:0]      a2;
  logic            stall;
  logic            we3;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd3;
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           issue_valid, issue_rd, a1, a2,
    input  alu_ready, mem_ready, stall, we3, a3, wd3
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           issue_valid, issue_rd, a1, a2,
    output alu_ready, mem_ready, stall, we3, a3, wd3
  );
endinterface

// File: rtl/cpu_wb_arbiter.sv
// cpu_wb_arbiter: round-robin ALU/load writeback arbiter feeding the register-file write port.
// Define CPU_WB_SCOREBOARD_EN to build the pending-register scoreboard and RAW stall.
module cpu_wb_arbiter #(parameter int XLEN = 32) (
  input  logic      clk,
  input  logic      rst,
  cpu_wb_if.slave   bus
);
  logic            last_mem;
  logic            grant_alu;
  logic            grant_mem;
  logic            xfer;
  logic [4:0]      rd_sel;
  logic [XLEN-1:0] data_sel;
  // last_mem=1 means MEM took the last transfer, so the ALU wins the next tie
  always_comb begin
    grant_alu = bus.alu_valid & (~bus.mem_valid | last_mem);
    grant_mem = bus.mem_valid & ~grant_alu;
    bus.alu_ready = ~rst & grant_alu;
    bus.mem_ready = ~rst & grant_mem;
    xfer = bus.alu_ready | bus.mem_ready;
    rd_sel = grant_alu ? bus.alu_rd : bus.mem_rd;
    data_sel = grant_alu ? bus.alu_data : bus.mem_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_mem <= 1'b1;
      bus.we3 <= 1'b0;
      bus.a3 <= '0;
      bus.wd3 <= '0;
    end else begin
      bus.we3 <= xfer & (rd_sel != 5'd0);
      if (xfer) begin
        last_mem <= grant_mem;
        bus.a3 <= rd_sel;
        bus.wd3 <= data_sel;
      end
    end
  end
`ifdef CPU_WB_SCOREBOARD_EN
  logic [31:0] pending;
  // the set is written after the clear so it wins on a same-edge collision
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else begin
      if (bus.we3) pending[bus.a3] <= 1'b0;
      if (bus.issue_valid && bus.issue_rd != 5'd0) pending[bus.issue_rd] <= 1'b1;
    end
  end
  assign bus.stall = ~rst & ((bus.a1 != 5'd0 && pending[bus.a1]) ||
                             (bus.a2 != 5'd0 && pending[bus.a2]));
`else
  logic unused_sb;
  assign unused_sb = ^{bus.issue_valid, bus.issue_rd, bus.a1, bus.a2};
  assign bus.stall = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// tb_cpu_wb_arbiter: directed self-checking bench for cpu_wb_arbiter
module tb_cpu_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   errs = 0;
  int   checks = 0;
`ifdef CPU_WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif
  cpu_wb_if #(.XLEN(32)) bus();
  cpu_wb_arbiter #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    bus.alu_valid = 0; bus.mem_valid = 0; bus.issue_valid = 0;
  endtask
  initial begin
    rst = 1;
    bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_data = 32'h1;
    bus.mem_valid = 1; bus.mem_rd = 5'd4; bus.mem_data = 32'h2;
    bus.issue_valid = 0; bus.issue_rd = 0; bus.a1 = 0; bus.a2 = 0;
    tick(); tick();
    chk("rst_we3", bus.we3, 0);
    chk("rst_a3", bus.a3, 0);
    chk("rst_wd3", bus.wd3, 0);
    chk("rst_alu_ready", bus.alu_ready, 0);
    chk("rst_mem_ready", bus.mem_ready, 0);
    chk("rst_stall", bus.stall, 0);
    rst = 0; idle();
    tick();
    chk("idle_we3", bus.we3, 0);
    // single ALU write
    bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1;
    chk("single_alu_ready", bus.alu_ready, 1);
    chk("single_mem_ready", bus.mem_ready, 0);
    tick();
    chk("single_we3", bus.we3, 1);
    chk("single_a3", bus.a3, 5);
    chk("single_wd3", bus.wd3, 32'hDEADBEEF);
    idle();
    tick();
    chk("single_we3_drop", bus.we3, 0);
    // contention from a fresh reset: ALU, MEM, ALU, MEM
    rst = 1; tick(); rst = 0;
    bus.alu_valid = 1; bus.alu_rd = 5'd1; bus.alu_data = 32'h11;
    bus.mem_valid = 1; bus.mem_rd = 5'd2; bus.mem_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_alu_ready", bus.alu_ready, (i % 2 == 0));
      chk("cont_mem_ready", bus.mem_ready, (i % 2 == 1));
      tick();
      chk("cont_we3", bus.we3, 1);
      chk("cont_a3", bus.a3, (i % 2 == 0) ? 1 : 2);
      chk("cont_wd3", bus.wd3, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    idle();
    tick();
    chk("cont_we3_drop", bus.we3, 0);
    // x0 discard on the load channel
    bus.mem_valid = 1; bus.mem_rd = 5'd0; bus.mem_data = 32'h55;
    #1;
    chk("x0_mem_ready", bus.mem_ready, 1);
    tick();
    chk("x0_we3", bus.we3, 0);
    bus.mem_rd = 5'd3; bus.mem_data = 32'h33;
    #1;
    chk("mem_only_ready", bus.mem_ready, 1);
    tick();
    chk("mem_only_we3", bus.we3, 1);
    chk("mem_only_a3", bus.a3, 3);
    idle();
    // last transfer was MEM, so a tie goes to the ALU
    bus.alu_valid = 1; bus.mem_valid = 1; bus.alu_rd = 5'd0;
    #1;
    chk("tie_alu_ready", bus.alu_ready, 1);
    chk("tie_mem_ready", bus.mem_ready, 0);
    tick();
    idle();
    // scoreboard: reserve x7 and wait for its writeback
    bus.issue_valid = 1; bus.issue_rd = 5'd7;
    tick();
    bus.issue_valid = 0; bus.a1 = 5'd7; bus.a2 = 5'd0;
    #1;
    chk("sb_stall_a1", bus.stall, SB);
    bus.a1 = 5'd0; bus.a2 = 5'd7;
    #1;
    chk("sb_stall_a2", bus.stall, SB);
    bus.a1 = 5'd7; bus.a2 = 5'd0;
    bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
    tick();
    idle();
    chk("sb_wb_we3", bus.we3, 1);
    chk("sb_stall_during_wb", bus.stall, SB);
    tick();
    chk("sb_stall_cleared", bus.stall, 0);
    bus.a1 = 5'd0;
    #1;
    chk("sb_x0_no_stall", bus.stall, 0);
    // same-edge set and clear on x9
    bus.issue_valid = 1; bus.issue_rd = 5'd9;
    tick();
    bus.issue_valid = 0;
    bus.alu_valid = 1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    tick();
    bus.alu_valid = 0;
    chk("same_edge_we3", bus.we3, 1);
    chk("same_edge_a3", bus.a3, 9);
    bus.issue_valid = 1; bus.issue_rd = 5'd9;
    tick();
    bus.issue_valid = 0; bus.a1 = 5'd9;
    #1;
    chk("same_edge_stall", bus.stall, SB);
    // write to unreserved x6 leaves x9 pending
    bus.alu_valid = 1; bus.alu_rd = 5'd6; bus.alu_data = 32'h66;
    tick(); idle(); tick();
    chk("unreserved_keeps", bus.stall, SB);
    bus.alu_valid = 1; bus.alu_rd = 5'd9;
    tick(); idle(); tick();
    chk("x9_cleared", bus.stall, 0);
    // reset right after an accepted ALU write
    bus.issue_valid = 1; bus.issue_rd = 5'd12;
    tick();
    bus.issue_valid = 0;
    bus.alu_valid = 1; bus.alu_rd = 5'd12; bus.alu_data = 32'hC;
    bus.a1 = 5'd12;
    #1;
    chk("mid_alu_ready", bus.alu_ready, 1);
    tick();
    rst = 1; bus.alu_valid = 0;
    #1;
    chk("mid_rst_stall", bus.stall, 0);
    tick();
    chk("mid_rst_we3", bus.we3, 0);
    rst = 0;
    #1;
    chk("post_rst_stall", bus.stall, 0);
    tick();
    chk("post_rst_we3", bus.we3, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
